// File: rtl/conv_inst_decoder.sv
// Expands one per-stride conv instruction into a registered MAC beat stream (feature/kernel addresses, tags).
// Latency: first beat two cycles after accept; one beat per cycle under mac_ready; backpressure holds all mac_* stable.
// Optional CONV_DECODER_PERF_CNT_EN adds beat/stall counters; otherwise perf outputs are tied to zero.
module conv_inst_decoder #(
    parameter int XLEN = 32,
    parameter int FAW  = 16,
    parameter int KAW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    output logic            decoder_ready,
    input  logic [FAW-1:0]  stride_feature_baseaddr,
    input  logic [KAW-1:0]  stride_kernel_baseaddr,
    input  logic [XLEN-1:0] stride_feature_chin,
    input  logic [XLEN-1:0] stride_feature_chout,
    input  logic [XLEN-1:0] stride_feature_width,
    input  logic [XLEN-1:0] stride_feature_height,
    input  logic [XLEN-1:0] stride_kernel_sizeh,
    input  logic [XLEN-1:0] stride_kernel_sizew,
    input  logic            stride_has_bias,
    input  logic            stride_has_relu,
    input  logic [FAW-1:0]  stride_wb_baseaddr,
    input  logic [XLEN-1:0] stride_wb_ch_offset,
    output logic            mac_valid,
    input  logic            mac_ready,
    output logic [FAW-1:0]  mac_faddr,
    output logic [KAW-1:0]  mac_kaddr,
    output logic            mac_first,
    output logic            mac_last,
    output logic            mac_bias,
    output logic            mac_relu,
    output logic [FAW-1:0]  mac_wbaddr,
    output logic            inst_done,
    output logic [31:0]     perf_beats,
    output logic [31:0]     perf_stalls
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [FAW-1:0]  fbase_l, wbbase_l, plane, ch_ptr, row_ptr;
    logic [KAW-1:0]  kbase_l;
    logic [XLEN-1:0] chin_l, chout_l, w_l, h_l, kh_l, kw_l, wboff_l;
    logic            bias_l, relu_l;
    logic [XLEN-1:0] co, ci, ky, kx;
    logic [XLEN-1:0] nci, nky, nkx;
    logic            hs, zero_dim, one_w, kx_wrap, ky_wrap, last_w, final_beat;

    assign decoder_ready = (state == IDLE) && !rst;
    assign inst_done     = (state == DONE);
    assign hs            = mac_valid && mac_ready;
    assign zero_dim      = (chin_l == '0) || (chout_l == '0) || (kh_l == '0) || (kw_l == '0);
    assign one_w         = (chin_l == XLEN'(1)) && (kh_l == XLEN'(1)) && (kw_l == XLEN'(1));
    assign kx_wrap       = (kx == kw_l - XLEN'(1));
    assign ky_wrap       = (ky == kh_l - XLEN'(1));
    assign last_w        = kx_wrap && ky_wrap && (ci == chin_l - XLEN'(1));
    // mac_last marks the end of an output channel, so the final beat is the last one of the last channel
    assign final_beat    = mac_last && (co == chout_l - XLEN'(1));
    assign nkx           = kx_wrap ? '0 : kx + XLEN'(1);
    assign nky           = kx_wrap ? (ky_wrap ? '0 : ky + XLEN'(1)) : ky;
    assign nci           = (kx_wrap && ky_wrap) ? ci + XLEN'(1) : ci;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (inst_valid && decoder_ready) state_nxt = LOAD;
            LOAD: state_nxt = zero_dim ? DONE : RUN;
            RUN:  if (hs && final_beat) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fbase_l <= '0; wbbase_l <= '0; kbase_l <= '0;
            chin_l <= '0; chout_l <= '0; w_l <= '0; h_l <= '0;
            kh_l <= '0; kw_l <= '0; wboff_l <= '0; bias_l <= 1'b0; relu_l <= 1'b0;
            plane <= '0; ch_ptr <= '0; row_ptr <= '0;
            co <= '0; ci <= '0; ky <= '0; kx <= '0;
            mac_valid <= 1'b0; mac_faddr <= '0; mac_kaddr <= '0;
            mac_first <= 1'b0; mac_last <= 1'b0; mac_bias <= 1'b0;
            mac_relu <= 1'b0; mac_wbaddr <= '0;
        end else begin
            case (state)
                IDLE: if (inst_valid) begin
                    fbase_l  <= stride_feature_baseaddr;
                    kbase_l  <= stride_kernel_baseaddr;
                    chin_l   <= stride_feature_chin;
                    chout_l  <= stride_feature_chout;
                    w_l      <= stride_feature_width;
                    h_l      <= stride_feature_height;
                    kh_l     <= stride_kernel_sizeh;
                    kw_l     <= stride_kernel_sizew;
                    bias_l   <= stride_has_bias;
                    relu_l   <= stride_has_relu;
                    wbbase_l <= stride_wb_baseaddr;
                    wboff_l  <= stride_wb_ch_offset;
                end
                LOAD: begin
                    plane      <= FAW'(w_l * h_l);
                    co <= '0; ci <= '0; ky <= '0; kx <= '0;
                    ch_ptr     <= fbase_l;
                    row_ptr    <= fbase_l;
                    mac_valid  <= !zero_dim;
                    mac_faddr  <= fbase_l;
                    mac_kaddr  <= kbase_l;
                    mac_first  <= 1'b1;
                    mac_last   <= one_w && !bias_l;
                    mac_bias   <= 1'b0;
                    mac_relu   <= relu_l;
                    mac_wbaddr <= wbbase_l;
                end
                RUN: if (hs) begin
                    mac_kaddr <= mac_kaddr + KAW'(1);
                    if (final_beat) begin
                        mac_valid <= 1'b0;
                        mac_first <= 1'b0;
                        mac_last  <= 1'b0;
                        mac_bias  <= 1'b0;
                    end else if (mac_last) begin
                        co <= co + XLEN'(1); ci <= '0; ky <= '0; kx <= '0;
                        ch_ptr     <= fbase_l;
                        row_ptr    <= fbase_l;
                        mac_faddr  <= fbase_l;
                        mac_wbaddr <= mac_wbaddr + FAW'(wboff_l);
                        mac_first  <= 1'b1;
                        mac_last   <= one_w && !bias_l;
                        mac_bias   <= 1'b0;
                    end else if (last_w) begin
                        mac_bias  <= 1'b1;
                        mac_faddr <= '0;
                        mac_first <= 1'b0;
                        mac_last  <= 1'b1;
                    end else begin
                        kx <= nkx; ky <= nky; ci <= nci;
                        mac_first <= 1'b0;
                        mac_last  <= !bias_l && (nci == chin_l - XLEN'(1)) &&
                                     (nky == kh_l - XLEN'(1)) && (nkx == kw_l - XLEN'(1));
                        // Pointers step by 1 / W / plane so no multiplier is needed per beat
                        if (!kx_wrap) begin
                            mac_faddr <= mac_faddr + FAW'(1);
                        end else if (!ky_wrap) begin
                            row_ptr   <= row_ptr + FAW'(w_l);
                            mac_faddr <= row_ptr + FAW'(w_l);
                        end else begin
                            ch_ptr    <= ch_ptr + plane;
                            row_ptr   <= ch_ptr + plane;
                            mac_faddr <= ch_ptr + plane;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CONV_DECODER_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_beats  <= '0;
            perf_stalls <= '0;
        end else begin
            if (hs)                      perf_beats  <= perf_beats + 32'd1;
            if (mac_valid && !mac_ready) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`else
    assign perf_beats  = '0;
    assign perf_stalls = '0;
`endif
endmodule

// File: tb/tb_conv_inst_decoder.sv
// Bench for conv_inst_decoder: directed plus randomized instructions against a loop-nest reference model.
module tb_conv_inst_decoder;
    localparam int XLEN = 32;
    localparam int FAW  = 20;
    localparam int KAW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inst_valid = 1'b0;
    logic decoder_ready;
    logic [FAW-1:0]  f_base = '0, wb_base = '0;
    logic [KAW-1:0]  k_base = '0;
    logic [XLEN-1:0] chin = '0, chout = '0, fw = '0, fh = '0, kh = '0, kw = '0, wb_off = '0;
    logic has_bias = 1'b0, has_relu = 1'b0;
    logic mac_valid, mac_ready = 1'b0;
    logic [FAW-1:0] mac_faddr, mac_wbaddr;
    logic [KAW-1:0] mac_kaddr;
    logic mac_first, mac_last, mac_bias, mac_relu, inst_done;
    logic [31:0] perf_beats, perf_stalls;

    int n_cmp = 0;
    int n_err = 0;
    int tot_beats = 0;
    int tot_stalls = 0;

    typedef struct {
        logic [FAW-1:0] faddr;
        logic [KAW-1:0] kaddr;
        logic [FAW-1:0] wbaddr;
        logic first, last, bias, relu;
    } beat_t;
    beat_t exp_q[$];

    conv_inst_decoder #(.XLEN(XLEN), .FAW(FAW), .KAW(KAW)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .decoder_ready(decoder_ready),
        .stride_feature_baseaddr(f_base), .stride_kernel_baseaddr(k_base),
        .stride_feature_chin(chin), .stride_feature_chout(chout),
        .stride_feature_width(fw), .stride_feature_height(fh),
        .stride_kernel_sizeh(kh), .stride_kernel_sizew(kw),
        .stride_has_bias(has_bias), .stride_has_relu(has_relu),
        .stride_wb_baseaddr(wb_base), .stride_wb_ch_offset(wb_off),
        .mac_valid(mac_valid), .mac_ready(mac_ready),
        .mac_faddr(mac_faddr), .mac_kaddr(mac_kaddr),
        .mac_first(mac_first), .mac_last(mac_last), .mac_bias(mac_bias), .mac_relu(mac_relu),
        .mac_wbaddr(mac_wbaddr), .inst_done(inst_done),
        .perf_beats(perf_beats), .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    task automatic set_inst(input int c_in, input int c_out, input int w, input int h,
                            input int k_h, input int k_w, input bit b, input bit r,
                            input int fb, input int kb, input int wbb, input int off);
        chin = XLEN'(c_in); chout = XLEN'(c_out); fw = XLEN'(w); fh = XLEN'(h);
        kh = XLEN'(k_h); kw = XLEN'(k_w); has_bias = b; has_relu = r;
        f_base = FAW'(fb); k_base = KAW'(kb); wb_base = FAW'(wbb); wb_off = XLEN'(off);
    endtask

    // Reference: straight loop nest with full multiplies, truncated to the port widths
    task automatic build_model();
        longint unsigned k;
        beat_t bt;
        exp_q.delete();
        k = 0;
        for (longint unsigned co = 0; co < longint'(chout); co++) begin
            for (longint unsigned ci = 0; ci < longint'(chin); ci++)
                for (longint unsigned y = 0; y < longint'(kh); y++)
                    for (longint unsigned x = 0; x < longint'(kw); x++) begin
                        bt.faddr  = FAW'(longint'(f_base) + ci * longint'(fw) * longint'(fh) + y * longint'(fw) + x);
                        bt.kaddr  = KAW'(longint'(k_base) + k);
                        bt.wbaddr = FAW'(longint'(wb_base) + co * longint'(wb_off));
                        bt.first  = (ci == 0) && (y == 0) && (x == 0);
                        bt.last   = !has_bias && (ci == longint'(chin) - 1) && (y == longint'(kh) - 1) && (x == longint'(kw) - 1);
                        bt.bias   = 1'b0;
                        bt.relu   = has_relu;
                        exp_q.push_back(bt);
                        k++;
                    end
            if (has_bias) begin
                bt.faddr  = '0;
                bt.kaddr  = KAW'(longint'(k_base) + k);
                bt.wbaddr = FAW'(longint'(wb_base) + co * longint'(wb_off));
                bt.first  = 1'b0;
                bt.last   = 1'b1;
                bt.bias   = 1'b1;
                bt.relu   = has_relu;
                exp_q.push_back(bt);
                k++;
            end
        end
    endtask

    // mode 0: ready always, 1: toggle each cycle, 2: random
    task automatic run_check(input string name, input int mode, input bit busy);
        int idx, stalls, done_cyc, last_hs, ndone;
        bit tog;
        build_model();
        @(negedge clk);
        n_cmp++;
        if (decoder_ready !== 1'b1) begin
            n_err++; $display("FAIL %s accept_ready: got %b want 1", name, decoder_ready);
        end
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        n_cmp++;
        if (decoder_ready !== 1'b0 || mac_valid !== 1'b0 || inst_done !== 1'b0) begin
            n_err++; $display("FAIL %s load_cycle: ready=%b valid=%b done=%b want 0 0 0",
                              name, decoder_ready, mac_valid, inst_done);
        end
        idx = 0; stalls = 0; done_cyc = -1; last_hs = 1; ndone = 0; tog = 1'b1;
        for (int cyc = 2; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (busy) begin
                if (cyc == 4) begin
                    inst_valid = 1'b1;
                    chout = XLEN'($urandom_range(1, 4));
                    chin = XLEN'($urandom_range(1, 4));
                    f_base = FAW'($urandom); k_base = KAW'($urandom); has_bias = ~has_bias;
                end else begin
                    inst_valid = 1'b0;
                end
            end
            if (cyc == 2) begin
                n_cmp++;
                if (mac_valid !== (exp_q.size() > 0)) begin
                    n_err++; $display("FAIL %s first_valid: got %b want %b", name, mac_valid, exp_q.size() > 0);
                end
            end
            n_cmp++;
            if (decoder_ready !== (done_cyc >= 0)) begin
                n_err++; $display("FAIL %s busy_ready cyc%0d: got %b want %b", name, cyc, decoder_ready, done_cyc >= 0);
            end
            if (inst_done === 1'b1) begin
                ndone++;
                n_cmp++;
                if (cyc != last_hs + 1 || idx != exp_q.size()) begin
                    n_err++; $display("FAIL %s done_timing: cyc=%0d beats=%0d want cyc=%0d beats=%0d",
                                      name, cyc, idx, last_hs + 1, exp_q.size());
                end
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (mac_valid === 1'b1) begin
                n_cmp++;
                if (idx >= exp_q.size()) begin
                    n_err++; $display("FAIL %s extra_beat: got beat %0d want %0d beats", name, idx, exp_q.size());
                end else if ({mac_faddr, mac_kaddr, mac_wbaddr, mac_first, mac_last, mac_bias, mac_relu} !==
                             {exp_q[idx].faddr, exp_q[idx].kaddr, exp_q[idx].wbaddr,
                              exp_q[idx].first, exp_q[idx].last, exp_q[idx].bias, exp_q[idx].relu}) begin
                    n_err++;
                    $display("FAIL %s beat%0d: got f=%h k=%h wb=%h fl=%b%b b=%b r=%b want f=%h k=%h wb=%h fl=%b%b b=%b r=%b",
                             name, idx, mac_faddr, mac_kaddr, mac_wbaddr, mac_first, mac_last, mac_bias, mac_relu,
                             exp_q[idx].faddr, exp_q[idx].kaddr, exp_q[idx].wbaddr, exp_q[idx].first,
                             exp_q[idx].last, exp_q[idx].bias, exp_q[idx].relu);
                end
            end
            case (mode)
                0: mac_ready = 1'b1;
                1: begin mac_ready = tog; tog = ~tog; end
                default: mac_ready = 1'($urandom_range(0, 1));
            endcase
            if (mac_valid === 1'b1 && mac_ready) begin
                idx++; last_hs = cyc;
            end else if (mac_valid === 1'b1) begin
                stalls++;
            end
            if (done_cyc >= 0 && cyc > done_cyc) break;
        end
        mac_ready = 1'b0;
        inst_valid = 1'b0;
        n_cmp++;
        if (ndone != 1 || idx != exp_q.size()) begin
            n_err++; $display("FAIL %s completion: dones=%0d beats=%0d want 1 and %0d", name, ndone, idx, exp_q.size());
        end
        tot_beats += idx;
        tot_stalls += stalls;
        n_cmp++;
`ifdef CONV_DECODER_PERF_CNT_EN
        if (perf_beats !== 32'(tot_beats) || perf_stalls !== 32'(tot_stalls)) begin
            n_err++; $display("FAIL %s perf: beats=%0d stalls=%0d want %0d %0d", name, perf_beats, perf_stalls, tot_beats, tot_stalls);
        end
`else
        if (perf_beats !== 32'd0 || perf_stalls !== 32'd0) begin
            n_err++; $display("FAIL %s perf_tied: beats=%0d stalls=%0d want 0 0", name, perf_beats, perf_stalls);
        end
`endif
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({decoder_ready, mac_valid, mac_faddr, mac_kaddr, mac_first, mac_last, mac_bias, mac_relu,
             mac_wbaddr, inst_done, perf_beats, perf_stalls} !== '0) begin
            n_err++; $display("FAIL reset_outputs: ready=%b valid=%b f=%h k=%h wb=%h done=%b want all 0",
                              decoder_ready, mac_valid, mac_faddr, mac_kaddr, mac_wbaddr, inst_done);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (decoder_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release_ready: got %b want 1", decoder_ready);
        end
    endtask

    task automatic test_basic();
        set_inst(2, 1, 4, 4, 2, 2, 0, 0, 'h100, 'h20, 'h3000, 16);
        run_check("basic", 0, 0);
    endtask

    task automatic test_bias_wb();
        set_inst(1, 2, 4, 4, 1, 1, 1, 1, 'h200, 'h40, 'h10000, 676);
        run_check("bias_wb", 0, 0);
    endtask

    task automatic test_backpressure();
        set_inst(2, 1, 4, 4, 2, 2, 0, 0, 'h100, 'h20, 'h3000, 16);
        run_check("backpressure", 1, 0);
    endtask

    task automatic test_zero_dim();
        set_inst(2, 0, 4, 4, 2, 2, 1, 0, 'h100, 'h20, 'h3000, 16);
        run_check("zero_chout", 0, 0);
        set_inst(3, 2, 5, 5, 0, 3, 0, 1, 'h700, 'h99, 'h100, 8);
        run_check("zero_kh", 2, 0);
    endtask

    task automatic test_reset_mid();
        int acc;
        set_inst(2, 1, 4, 4, 2, 2, 0, 0, 'h100, 'h20, 'h3000, 16);
        @(negedge clk);
        inst_valid = 1'b1;
        mac_ready = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        acc = 0;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            @(negedge clk);
            if (mac_valid === 1'b1) acc++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (acc != 4 || mac_valid !== 1'b0 || decoder_ready !== 1'b0 || inst_done !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_immediate: beats=%0d valid=%b ready=%b done=%b want 4 0 0 0",
                              acc, mac_valid, decoder_ready, inst_done);
        end
        mac_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (inst_done !== 1'b0 || mac_valid !== 1'b0) begin
                n_err++; $display("FAIL reset_mid_hold: done=%b valid=%b want 0 0", inst_done, mac_valid);
            end
        end
        rst = 1'b0;
        tot_beats = 0;
        tot_stalls = 0;
        run_check("after_reset", 0, 0);
    endtask

    task automatic test_busy_ignore();
        set_inst(2, 1, 4, 4, 2, 2, 0, 1, 'h100, 'h20, 'h3000, 16);
        run_check("busy_ignore", 2, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            set_inst($urandom_range(1, 3), ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3),
                     $urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 3), $urandom_range(1, 3),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom), int'($urandom), int'($urandom), int'($urandom_range(0, 5000)));
            run_check("random", $urandom_range(0, 2), 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bias_wb();
        test_backpressure();
        test_zero_dim();
        test_reset_mid();
        test_busy_ignore();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/conv_inst_decoder.md
# conv_inst_decoder

Downstream consumer of the convolution instruction generator. It accepts one per-stride instruction per valid/ready handshake. Each instruction covers one output pixel window across all output channels. The block expands it into a registered beat stream of feature-RAM/kernel-RAM read addresses, with accumulate and writeback tags, for the MAC array. One instruction in flight at a time; completion is reported with a one-cycle pulse.

## Interface
- XLEN, 32, width of scalar geometry fields
- FAW, 16, feature RAM address width
- KAW, 16, kernel RAM address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- inst_valid  in  1  instruction valid from instgen
- decoder_ready  out  1  ready to accept instruction
- stride_feature_baseaddr  in  FAW  window origin in feature RAM
- stride_kernel_baseaddr  in  KAW  first kernel word
- stride_feature_chin / stride_feature_chout  in  XLEN  input/output channels
- stride_feature_width / stride_feature_height  in  XLEN  feature plane W/H
- stride_kernel_sizeh / stride_kernel_sizew  in  XLEN  kernel KH/KW
- stride_has_bias / stride_has_relu  in  1  bias beat per channel / relu tag
- stride_wb_baseaddr  in  FAW  writeback address of channel 0
- stride_wb_ch_offset  in  XLEN  writeback stride between channels
- mac_valid  out  1  beat valid
- mac_ready  in  1  MAC array accepts beat
- mac_faddr  out  FAW  feature read address (0 on bias beats)
- mac_kaddr  out  KAW  kernel read address
- mac_first / mac_last  out  1  first/last beat of current output channel
- mac_bias / mac_relu  out  1  bias beat / relu applies to channel
- mac_wbaddr  out  FAW  writeback address of current channel
- inst_done  out  1  one-cycle pulse, instruction fully issued
- perf_beats / perf_stalls  out  32  performance counters (see Configuration)

## Operation
- States: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE: decoder_ready=1. On inst_valid && decoder_ready, latch all stride_* fields and go to LOAD.
- LOAD: compute plane = W*H (FAW bits, truncated) and clear loop counters co, ci, ky, kx.
  - If any of chin, chout, KH, KW is 0, go to DONE with no beats.
  - Otherwise go to RUN.
- RUN loop order, outer to inner: co, ci, ky, kx. If has_bias, one bias beat follows the weight beats of each co.
- Beats per instruction: chout*(chin*KH*KW + has_bias).
- Weight beat fields:
  - mac_faddr = fbase + ci*plane + ky*W + kx, mod 2^FAW. Computed incrementally with channel and row pointer registers; no multiplier in RUN.
  - mac_kaddr = kbase + running beat index (bias beats included), mod 2^KAW.
  - mac_wbaddr = wbbase + co*wb_ch_offset, mod 2^FAW. Accumulated per co.
- mac_first: first weight beat of each co.
- mac_last: final beat of each co (bias beat if has_bias, else last weight beat).
- mac_relu = latched has_relu on every beat.
- Backpressure: a beat advances only when mac_valid && mac_ready. While stalled, all mac_* outputs hold stable.
- After the last beat is accepted, go to DONE. DONE asserts inst_done for one cycle, then returns to IDLE.

## Timing
- Reset values: decoder_ready=0 while rst is high, 1 in the first cycle after release. All other outputs 0, state IDLE, counters 0.
- Instruction accepted at edge T:
  - LOAD during T+1.
  - mac_valid high from T+2.
  - Zero-dimension case: inst_done high during T+2.
- decoder_ready is low from T+1 until the cycle after DONE.
- With mac_ready held 1: one beat per cycle, no bubbles between channels or around bias beats. inst_done is high in the cycle after the last handshake.
- mac_* are registered outputs; no combinational path from mac_ready to mac_valid.
- inst_valid while busy is ignored; no queuing.
- rst mid-operation immediately discards the in-flight instruction and forces reset values. No inst_done is produced for it.

## Configuration
- CONV_DECODER_PERF_CNT_EN defined:
  - perf_beats counts accepted beats.
  - perf_stalls counts cycles with mac_valid && !mac_ready.
  - Both are 32-bit, wrap at 2^32, cleared only by rst.
- Undefined: perf_beats and perf_stalls are tied to 0 and the counter logic is absent.

## Test plan
- Basic window: W=H=4, chin=2, chout=1, KH=KW=2, fbase=0x100, kbase=0x20, no bias, mac_ready=1.
  - 8 beats, faddr 0x100,0x101,0x104,0x105,0x110,0x111,0x114,0x115; kaddr 0x20..0x27.
  - first on beat 0, last on beat 7; inst_done 1 cycle after beat 7.
- Bias/writeback: chin=1, chout=2, KH=KW=1, has_bias=1, kbase=0x40, wbbase=0x10000, offset=676.
  - 4 beats, mac_bias on beats 1 and 3; kaddr 0x40..0x43.
  - wbaddr 0x10000 on beats 0-1, 0x102A4 on beats 2-3; mac_last on beats 1 and 3.
- Backpressure: test 1 with mac_ready toggling 1/0 each cycle.
  - Same 8-beat sequence; outputs stable during stalls.
  - With CONV_DECODER_PERF_CNT_EN: perf_beats=8 and perf_stalls equals the stall cycles counted by the bench.
- Zero dimension: chout=0 accepted at T -> no mac_valid; inst_done during T+2; decoder_ready=1 at T+3.
- Reset mid-run: assert rst after beat 3 of test 1.
  - mac_valid=0 and decoder_ready=0 immediately; no inst_done.
  - Next instruction after release starts fresh at kaddr=kbase.
- Busy ignore: pulse inst_valid with different fields during RUN -> original stream unaffected, exactly one inst_done.
